pcileech_tlps_rx_framer: RTL and testbench
==========================================

Name: pcileech_tlps_rx_framer

Overview:
Sits directly downstream of the PCIe TLP RX FIFO on the 100MHz side. It pops DWORDs through the FIFO's rd_en/valid read interface and collects one complete TLP in a local buffer. It then emits the TLP as a framed 32-bit stream toward the FT601 mux: one header DWORD carrying magic, sequence number and length, followed by the payload. Oversize TLPs are dropped whole and counted, so the host only ever sees complete TLPs.

Parameters:
MAX_DW, 256, maximum TLP length in DWORDs, including the TLP header. Legal range 4..1023.
MAGIC, 8'hCF, value placed in framing header bits [31:24].

Ports:
clk  in  1  100MHz system clock.
rst  in  1  synchronous, active-high reset.
pcie_tlp_rx_data  in  32  DWORD from RX FIFO.
pcie_tlp_rx_last  in  1  DWORD is last of its TLP; qualified by valid.
pcie_tlp_rx_valid  in  1  data/last valid. Asserted 1 cycle after an accepted rd_en; may be 0 for an issued read.
pcie_tlp_rx_empty  in  1  RX FIFO empty.
pcie_tlp_rx_rd_en  out  1  pop request to RX FIFO.
dout_data  out  32  framed output DWORD.
dout_last  out  1  final DWORD of frame.
dout_valid  out  1  output valid.
dout_ready  in  1  downstream accepts when valid&ready.
stat_drop_cnt  out  16  count of dropped oversize TLPs; saturates at 16'hFFFF.

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Reset values: rd_en=0, dout_valid=0, dout_last=0, dout_data=0, stat_drop_cnt=0. Sequence counter=0, state=FILL, word count=0, skid register empty.
- Reset mid-operation discards any partial TLP and any un-emitted frame. The shared rst also clears the RX FIFO.
- Read rule: rd_en = ~empty & (state==FILL or DROP) & ~skid_full & ~last_seen.
  - last_seen is set when a valid&last word arrives and cleared on the transition back to FILL.
- One read may be in flight when last is observed. A valid word arriving outside FILL/DROP, or after last_seen, goes into a 1-entry skid register. It is consumed as the first word of the next FILL.
- A valid=0 result of an issued read (odd-DWORD padding entry) is ignored. It does not count as a word.
- States:
  - FILL: each valid word is written to buf[count], then count++.
    - valid&last with count+1 <= MAX_DW -> latch len=count+1, go to EMIT.
    - valid&~last with count == MAX_DW-1 -> go to DROP (the buffer is full with no last yet).
  - DROP: discard words until valid&last. Then stat_drop_cnt++ (saturating), go to FILL with count=0. The sequence counter is unchanged.
  - EMIT: first the header {MAGIC, seq[7:0], 6'b0, len[9:0]}, then buf[0..len-1] in order. dout_last is asserted with buf[len-1].
    - On the last handshake: seq++ (wraps 255->0), count=0, go to FILL.
- Output handshake: dout_* hold stable while dout_valid & ~dout_ready, and dout_valid never drops without a handshake.
  - Header dout_valid rises 1 cycle after entering EMIT.
  - With dout_ready=1 throughout, sustained throughput is 1 DWORD/cycle (buffer sync read, prefetched).
- A frame is emitted only after the complete TLP has been buffered (store-and-forward). There is no overlap of FILL and EMIT, except that the skid register may fill during EMIT.
- A TLP of exactly MAX_DW DWORDs is accepted. MAX_DW+1 or more is dropped.

Decomposition:
- Package pcileech_tlps_pkg holds:
  - MAGIC default
  - header field positions (MAGIC [31:24], SEQ [23:16], LEN [9:0])
  - state enum FILL/DROP/EMIT
- Sub-module pcileech_tlps_buf: simple dual-port RAM, MAX_DW x 32, 1 write port and 1 synchronous read port.

Test Plan:
1. Single 3DW TLP 0x00000001, 0x0000000F, 0x12345678 (last on 3rd), dout_ready=1 -> output 0xCF000003, 0x00000001, 0x0000000F, 0x12345678. dout_last on 4th output word only; stat_drop_cnt=0.
2. Two back-to-back 4DW TLPs with dout_ready low for 10 cycles mid-frame -> frames 0xCF000004… then 0xCF010004… in order with no loss or duplication. Data stays stable while stalled, and rd_en stays 0 once the skid register is full.
3. TLP of MAX_DW+1=257 DWORDs followed by a 3DW TLP -> no frame for the first; stat_drop_cnt=1. Second frame header is 0xCF000003 (seq not advanced).
4. TLP of exactly 256 DWORDs -> header 0xCF000100, 256 payload DWORDs, dout_last on the 257th output word.
5. Reads returning valid=0 interleaved between valid words of a 4DW TLP -> frame length 4 with the correct order; the padding entries are ignored.
6. rst asserted for 1 cycle mid-FILL (2 of 5 DWORDs received), then a new 3DW TLP -> no partial frame is emitted. Next header is 0xCF000003, and stat_drop_cnt=0.

Source files
------------

// File: rtl/pcileech_tlps_pkg.sv
// Shared types and framing-header layout for the TLP RX framer.
// Header DWORD: {MAGIC[31:24], SEQ[23:16], 6'b0, LEN[9:0]}.
package pcileech_tlps_pkg;

   localparam logic [7:0] MAGIC_DEFAULT = 8'hCF;

   localparam int HDR_MAGIC_LSB = 24;
   localparam int HDR_SEQ_LSB   = 16;
   localparam int HDR_LEN_LSB   = 0;
   localparam int HDR_LEN_W     = 10;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      DROP = 2'd1,
      EMIT = 2'd2
   } tlps_state_t;

   function automatic logic [31:0] make_hdr(input logic [7:0] magic,
                                            input logic [7:0] seq,
                                            input logic [HDR_LEN_W-1:0] len);
      logic [31:0] h;
      h = '0;
      h[HDR_MAGIC_LSB +: 8]       = magic;
      h[HDR_SEQ_LSB +: 8]         = seq;
      h[HDR_LEN_LSB +: HDR_LEN_W] = len;
      return h;
   endfunction

endpackage

// File: rtl/pcileech_tlps_rx_framer_if.sv
// RX FIFO read port, framed output stream and drop statistic of the framer.
// master = framer side, slave = FIFO / downstream mux side.
interface pcileech_tlps_rx_framer_if;

   logic [31:0] pcie_tlp_rx_data;
   logic        pcie_tlp_rx_last;
   logic        pcie_tlp_rx_valid;
   logic        pcie_tlp_rx_empty;
   logic        pcie_tlp_rx_rd_en;
   logic [31:0] dout_data;
   logic        dout_last;
   logic        dout_valid;
   logic        dout_ready;
   logic [15:0] stat_drop_cnt;

   modport master (
      input  pcie_tlp_rx_data, pcie_tlp_rx_last, pcie_tlp_rx_valid, pcie_tlp_rx_empty,
      output pcie_tlp_rx_rd_en,
      output dout_data, dout_last, dout_valid,
      input  dout_ready,
      output stat_drop_cnt
   );

   modport slave (
      output pcie_tlp_rx_data, pcie_tlp_rx_last, pcie_tlp_rx_valid, pcie_tlp_rx_empty,
      input  pcie_tlp_rx_rd_en,
      input  dout_data, dout_last, dout_valid,
      output dout_ready,
      input  stat_drop_cnt
   );

endinterface

// File: rtl/pcileech_tlps_buf.sv
// TLP store: simple dual-port RAM, one write port, one synchronous read port.
// Read data appears one cycle after raddr; no reset on the array.
module pcileech_tlps_buf #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/pcileech_tlps_rx_framer.sv
// Store-and-forward framer: buffers one whole TLP, then emits header + payload at 1 DW/cycle.
// Header valid one cycle after the TLP completes; output holds under ~dout_ready, oversize TLPs dropped.
module pcileech_tlps_rx_framer
   import pcileech_tlps_pkg::*;
#(
   parameter int         MAX_DW = 256,
   parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
   input logic                        clk,
   input logic                        rst,
   pcileech_tlps_rx_framer_if.master  bus
);

   localparam int         AW       = $clog2(MAX_DW);
   localparam logic [9:0] CNT_LAST = 10'(MAX_DW - 1);

   tlps_state_t state;
   logic [9:0]  count;
   logic [9:0]  len;
   logic [9:0]  nidx;
   logic [9:0]  nidx_nxt;
   logic [7:0]  seq;
   logic        last_seen;
   logic        skid_full;
   logic        skid_last;
   logic [31:0] skid_data;
   logic [15:0] drop_cnt;
   logic [31:0] dout_data;
   logic        dout_last;
   logic        dout_valid;

   logic        rx_take;
   logic        rx_skid;
   logic        in_vld;
   logic        in_last;
   logic [31:0] in_data;
   logic        hs;
   logic        adv;
   logic [AW-1:0] raddr;
   logic [31:0] rdata;

   // A word returning while we emit (or after last) is the in-flight read: park it in the skid.
   assign rx_take  = bus.pcie_tlp_rx_valid & (state != EMIT) & ~last_seen;
   assign rx_skid  = bus.pcie_tlp_rx_valid & ~rx_take;
   assign in_vld   = (state == FILL) & (skid_full | rx_take);
   assign in_data  = skid_full ? skid_data : bus.pcie_tlp_rx_data;
   assign in_last  = skid_full ? skid_last : bus.pcie_tlp_rx_last;

   assign hs       = dout_valid & bus.dout_ready;
   assign adv      = (state == EMIT) & hs & ~dout_last;
   assign nidx_nxt = nidx + 10'd1;
   // rdata always holds buf[nidx]; step the address on each accepted word to keep it prefetched.
   assign raddr    = adv ? nidx_nxt[AW-1:0] : nidx[AW-1:0];

   assign bus.pcie_tlp_rx_rd_en = ~rst & ~bus.pcie_tlp_rx_empty & (state != EMIT)
                                  & ~skid_full & ~last_seen;
   assign bus.dout_data     = dout_data;
   assign bus.dout_last     = dout_last;
   assign bus.dout_valid    = dout_valid;
   assign bus.stat_drop_cnt = drop_cnt;

   pcileech_tlps_buf #(
      .DEPTH (MAX_DW),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .we    (in_vld),
      .waddr (count[AW-1:0]),
      .wdata (in_data),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         count      <= '0;
         len        <= '0;
         nidx       <= '0;
         seq        <= '0;
         last_seen  <= 1'b0;
         skid_full  <= 1'b0;
         skid_last  <= 1'b0;
         skid_data  <= '0;
         drop_cnt   <= '0;
         dout_data  <= '0;
         dout_last  <= 1'b0;
         dout_valid <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (in_vld) begin
                  skid_full <= 1'b0;
                  if (in_last) begin
                     len       <= count + 10'd1;
                     last_seen <= 1'b1;
                     state     <= EMIT;
                  end else if (count == CNT_LAST) begin
                     state <= DROP;
                  end else begin
                     count <= count + 10'd1;
                  end
               end
            end
            DROP: begin
               if (rx_take && bus.pcie_tlp_rx_last) begin
                  if (drop_cnt != 16'hFFFF) begin
                     drop_cnt <= drop_cnt + 16'd1;
                  end
                  count <= '0;
                  state <= FILL;
               end
            end
            EMIT: begin
               if (!dout_valid) begin
                  dout_valid <= 1'b1;
                  dout_last  <= 1'b0;
                  dout_data  <= make_hdr(MAGIC, seq, len);
               end else if (hs) begin
                  if (dout_last) begin
                     dout_valid <= 1'b0;
                     dout_last  <= 1'b0;
                     seq        <= seq + 8'd1;
                     count      <= '0;
                     nidx       <= '0;
                     last_seen  <= 1'b0;
                     state      <= FILL;
                  end else begin
                     dout_data <= rdata;
                     dout_last <= (nidx_nxt == len);
                     nidx      <= nidx_nxt;
                  end
               end
            end
            default: state <= FILL;
         endcase

         if (rx_skid) begin
            skid_full <= 1'b1;
            skid_data <= bus.pcie_tlp_rx_data;
            skid_last <= bus.pcie_tlp_rx_last;
         end
      end
   end

endmodule

// File: tb/tb_pcileech_tlps_rx_framer.sv
// Bench: queue-based RX FIFO model, frame-level reference model, per-cycle output compare.
module tb_pcileech_tlps_rx_framer;

   localparam int MAX_DW = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pcileech_tlps_rx_framer_if bus ();

   pcileech_tlps_rx_framer #(.MAX_DW(MAX_DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [33:0] fifo_q[$];   // {real, last, data}
   logic [32:0] exp_q[$];    // {last, data}
   logic [32:0] got_q[$];
   logic [31:0] pay[$];
   logic [7:0]  m_seq = 8'd0;
   int          m_drop = 0;
   int          ready_mode = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // RX FIFO: read data comes back one cycle after an accepted rd_en.
   initial begin
      logic        take;
      logic [33:0] e;
      bus.pcie_tlp_rx_valid = 1'b0;
      bus.pcie_tlp_rx_last  = 1'b0;
      bus.pcie_tlp_rx_data  = '0;
      bus.pcie_tlp_rx_empty = 1'b1;
      forever begin
         @(negedge clk);
         take = bus.pcie_tlp_rx_rd_en;
         @(posedge clk);
         if (rst) begin
            fifo_q.delete();
            take = 1'b0;
         end
         #1;
         if (take && fifo_q.size() > 0) begin
            e = fifo_q.pop_front();
            bus.pcie_tlp_rx_valid = e[33];
            bus.pcie_tlp_rx_last  = e[32];
            bus.pcie_tlp_rx_data  = e[31:0];
         end else begin
            bus.pcie_tlp_rx_valid = 1'b0;
            bus.pcie_tlp_rx_last  = 1'($urandom_range(0, 1));
            bus.pcie_tlp_rx_data  = 32'($urandom);
         end
         bus.pcie_tlp_rx_empty = (fifo_q.size() == 0);
      end
   end

   initial begin
      bus.dout_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.dout_ready = 1'b1;
            1:       bus.dout_ready = 1'($urandom_range(0, 1));
            default: bus.dout_ready = 1'b0;
         endcase
      end
   end

   // Output compare: every handshake against the model queue, plus hold-while-stalled.
   initial begin
      logic        prev_stall;
      logic [32:0] prev;
      logic [32:0] cur;
      logic [32:0] e;
      prev_stall = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {bus.dout_last, bus.dout_data};
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               check("hold_stable", {30'b0, bus.dout_valid, cur}, {30'b0, 1'b1, prev});
            if (bus.dout_valid && bus.dout_ready) begin
               got_q.push_back(cur);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word actual=%0h required=none", cur);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_word", {31'b0, cur}, {31'b0, e});
               end
            end
            prev_stall = bus.dout_valid & ~bus.dout_ready;
            prev = cur;
         end
      end
   end

   task automatic send_pay(input int pad_pct);
      int n;
      n = pay.size();
      for (int i = 0; i < n; i++) begin
         if (int'($urandom_range(0, 99)) < pad_pct)
            fifo_q.push_back({1'b0, 1'($urandom_range(0, 1)), 32'($urandom)});
         fifo_q.push_back({1'b1, (i == n - 1), pay[i]});
      end
      if (n > MAX_DW) begin
         m_drop++;
      end else begin
         exp_q.push_back({1'b0, 8'hCF, m_seq, 6'b0, 10'(n)});
         for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1), pay[i]});
         m_seq++;
      end
   endtask

   task automatic rand_pay(input int n);
      pay.delete();
      for (int i = 0; i < n; i++)
         pay.push_back(32'($urandom));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_seq = 8'd0;
      m_drop = 0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      got_q.delete();
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20000 && (exp_q.size() != 0 || fifo_q.size() != 0); i++)
         @(negedge clk);
      repeat (8) @(negedge clk);
      check({name, "_pending_words"}, 64'(exp_q.size()), 64'd0);
      check({name, "_idle_valid"}, {63'b0, bus.dout_valid}, 64'd0);
      check({name, "_drop_cnt"}, {48'b0, bus.stat_drop_cnt}, 64'(m_drop));
   endtask

   initial begin
      int stall_rd;
      int n;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rd_en",      {63'b0, bus.pcie_tlp_rx_rd_en}, 64'd0);
      check("rst_dout_valid", {63'b0, bus.dout_valid}, 64'd0);
      check("rst_dout_last",  {63'b0, bus.dout_last}, 64'd0);
      check("rst_dout_data",  {32'b0, bus.dout_data}, 64'd0);
      check("rst_drop_cnt",   {48'b0, bus.stat_drop_cnt}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single 3DW TLP
      pay.delete();
      pay.push_back(32'h00000001);
      pay.push_back(32'h0000000F);
      pay.push_back(32'h12345678);
      send_pay(0);
      drain("t1");
      check("t1_words", 64'(got_q.size()), 64'd4);
      check("t1_w0", {31'b0, got_q[0]}, {31'b0, 1'b0, 32'hCF000003});
      check("t1_w1", {31'b0, got_q[1]}, {31'b0, 1'b0, 32'h00000001});
      check("t1_w2", {31'b0, got_q[2]}, {31'b0, 1'b0, 32'h0000000F});
      check("t1_w3", {31'b0, got_q[3]}, {31'b0, 1'b1, 32'h12345678});

      // two back-to-back 4DW TLPs with a 10-cycle stall mid-frame
      do_reset();
      rand_pay(4); send_pay(0);
      rand_pay(4); send_pay(0);
      for (int i = 0; i < 2000 && got_q.size() < 2; i++) @(negedge clk);
      check("t2_started", {63'b0, got_q.size() >= 2}, 64'd1);
      ready_mode = 2;
      stall_rd = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.pcie_tlp_rx_rd_en) stall_rd++;
      end
      ready_mode = 0;
      check("t2_rd_en_stall", 64'(stall_rd), 64'd0);
      drain("t2");
      check("t2_words", 64'(got_q.size()), 64'd10);
      check("t2_hdr0", {32'b0, got_q[0][31:0]}, {32'b0, 32'hCF000004});
      check("t2_hdr1", {32'b0, got_q[5][31:0]}, {32'b0, 32'hCF010004});

      // oversize TLP dropped, following TLP keeps seq 0
      do_reset();
      rand_pay(MAX_DW + 1); send_pay(0);
      rand_pay(3); send_pay(0);
      drain("t3");
      check("t3_words", 64'(got_q.size()), 64'd4);
      check("t3_hdr", {31'b0, got_q[0]}, {31'b0, 1'b0, 32'hCF000003});
      check("t3_drop_literal", {48'b0, bus.stat_drop_cnt}, 64'd1);

      // exactly MAX_DW accepted
      do_reset();
      rand_pay(MAX_DW); send_pay(0);
      drain("t4");
      check("t4_words", 64'(got_q.size()), 64'd257);
      check("t4_hdr", {31'b0, got_q[0]}, {31'b0, 1'b0, 32'hCF000100});
      check("t4_last_256", {63'b0, got_q[256][32]}, 64'd1);
      check("t4_last_255", {63'b0, got_q[255][32]}, 64'd0);

      // padding (valid=0) reads interleaved
      do_reset();
      rand_pay(4); send_pay(70);
      drain("t5");
      check("t5_words", 64'(got_q.size()), 64'd5);
      check("t5_hdr", {31'b0, got_q[0]}, {31'b0, 1'b0, 32'hCF000004});

      // reset mid-FILL discards the partial TLP
      do_reset();
      fifo_q.push_back({1'b1, 1'b0, 32'hAAAA0001});
      fifo_q.push_back({1'b1, 1'b0, 32'hAAAA0002});
      repeat (10) @(negedge clk);
      check("t6_no_partial", 64'(got_q.size()), 64'd0);
      do_reset();
      rand_pay(3); send_pay(0);
      drain("t6");
      check("t6_hdr", {31'b0, got_q[0]}, {31'b0, 1'b0, 32'hCF000003});

      // randomized traffic with random backpressure
      do_reset();
      ready_mode = 1;
      for (int k = 0; k < 24; k++) begin
         n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(MAX_DW - 3, MAX_DW + 3))
                                         : int'($urandom_range(1, 10));
         rand_pay(n);
         send_pay(int'($urandom_range(0, 40)));
         repeat ($urandom_range(0, 20)) @(posedge clk);
      end
      drain("rand");
      ready_mode = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
